uart_reg_arb: RTL and testbench

Round-robin register-bus arbiter that lets several bus masters (e.g. the Wishbone bridge and the boot/debug loader) share the single byte-wide register port of the UART core (`uart_cfg` side). It registers one requester's command and drives it onto the UART register bus. It waits for the UART's `reg_ack`, or for a timeout if no ack arrives, then returns read data and a one-cycle ack to the winner. Sits between the SoC-side requesters and `uart_core` in the `app_clk` domain.

---
 rtl/uart_reg_arb_if.sv | 38 +++
 rtl/uart_reg_arb.sv | 176 +++++++++++++++++
 tb/tb_uart_reg_arb.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_reg_arb_if.sv
// Register-bus bundle between the SoC requesters, the arbiter and the UART
// register port. The arbiter takes the slave view; the requesters and the
// UART core together form the master view.
interface uart_reg_arb_if #(
   parameter int NR = 2
);
   // requester side
   logic [NR-1:0]   req_cs;
   logic [NR-1:0]   req_wr;
   logic [NR*4-1:0] req_addr;
   logic [NR*8-1:0] req_wdata;
   logic [NR-1:0]   req_be;
   logic [7:0]      req_rdata;
   logic [NR-1:0]   req_ack;

   // UART register side
   logic            reg_cs;
   logic            reg_wr;
   logic            reg_be;
   logic [3:0]      reg_addr;
   logic [7:0]      reg_wdata;
   logic [7:0]      reg_rdata;
   logic            reg_ack;

   modport slave (
      input  req_cs, req_wr, req_addr, req_wdata, req_be,
      output req_rdata, req_ack,
      output reg_cs, reg_wr, reg_be, reg_addr, reg_wdata,
      input  reg_rdata, reg_ack
   );

   modport master (
      output req_cs, req_wr, req_addr, req_wdata, req_be,
      input  req_rdata, req_ack,
      input  reg_cs, reg_wr, reg_be, reg_addr, reg_wdata,
      output reg_rdata, reg_ack
   );
endinterface

// File: rtl/uart_reg_arb.sv
// Round-robin arbiter sharing the UART byte-wide register port among NR
// requesters. One access at a time: grant, hold the command until the UART
// acks (or the timeout expires), then pulse the winner's ack for one cycle.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | no access in flight; pick a winner from req_cs
// ST_ACCESS | reg_cs high, command held, waiting for reg_ack / timeout
// ST_ACK    | req_ack[gnt_id] high for one cycle, advance the pointer
module uart_reg_arb #(
   parameter int NR     = 2,
   parameter int TO_CYC = 255
) (
   input  logic                    mclk,
   input  logic                    reset_n,
   uart_reg_arb_if.slave           bus,
   output logic [$clog2(NR)-1:0]   gnt_id,
   output logic                    to_err,
   input  logic                    to_clr
);

   localparam int GW = $clog2(NR);
   // a zero-width counter is not legal, so keep one bit when the timeout is off
   localparam int CW = (TO_CYC > 0) ? $clog2(TO_CYC + 1) : 1;
   localparam logic [CW-1:0] TO_LAST = CW'((TO_CYC > 0) ? TO_CYC - 1 : 0);
   localparam logic [GW:0]   NR_W    = (GW + 1)'(NR);
   localparam logic [GW-1:0] LAST_ID = GW'(NR - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_ACK
   } state_t;

   state_t          state;
   state_t          state_nxt;

   logic [GW-1:0]   ptr;
   logic [GW-1:0]   win_id;
   logic            win_vld;
   logic [GW:0]     cand;
   logic [CW-1:0]   to_cnt;
   logic            to_hit;
   logic            to_set;

   logic [3:0]      addr_arr  [NR];
   logic [7:0]      wdata_arr [NR];

   // unpack the flat per-requester address and data buses
   always_comb begin
      for (int i = 0; i < NR; i++) begin
         addr_arr[i]  = bus.req_addr[4*i +: 4];
         wdata_arr[i] = bus.req_wdata[8*i +: 8];
      end
   end

   // first requesting index at or above ptr, wrapping past NR-1
   always_comb begin
      win_vld = 1'b0;
      win_id  = ptr;
      cand    = '0;
      for (int k = 0; k < NR; k++) begin
         cand = {1'b0, ptr} + (GW + 1)'(k);
         if (cand >= NR_W) begin
            cand = cand - NR_W;
         end
         if (!win_vld && bus.req_cs[cand[GW-1:0]]) begin
            win_vld = 1'b1;
            win_id  = cand[GW-1:0];
         end
      end
   end

   // a timeout only counts when no ack arrives in the same cycle
   assign to_hit = (TO_CYC != 0) && (to_cnt == TO_LAST);
   assign to_set = (state == ST_ACCESS) && !bus.reg_ack && to_hit;

   // next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (win_vld) begin
               state_nxt = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (bus.reg_ack || to_hit) begin
               state_nxt = ST_ACK;
            end
         end
         ST_ACK: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // state register
   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // registered bus outputs, grant bookkeeping and timeout counter
   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n) begin
         bus.reg_cs    <= 1'b0;
         bus.reg_wr    <= 1'b0;
         bus.reg_be    <= 1'b0;
         bus.reg_addr  <= '0;
         bus.reg_wdata <= '0;
         bus.req_rdata <= '0;
         bus.req_ack   <= '0;
         gnt_id        <= '0;
         ptr           <= '0;
         to_cnt        <= '0;
      end else begin
         bus.req_ack <= '0;
         case (state)
            ST_IDLE: begin
               if (win_vld) begin
                  bus.reg_cs    <= 1'b1;
                  bus.reg_wr    <= bus.req_wr[win_id];
                  bus.reg_be    <= bus.req_be[win_id];
                  bus.reg_addr  <= addr_arr[win_id];
                  bus.reg_wdata <= wdata_arr[win_id];
                  gnt_id        <= win_id;
                  to_cnt        <= '0;
               end
            end
            ST_ACCESS: begin
               if (to_cnt != {CW{1'b1}}) begin
                  to_cnt <= to_cnt + 1'b1;
               end
               if (bus.reg_ack) begin
                  bus.req_rdata       <= bus.reg_rdata;
                  bus.reg_cs          <= 1'b0;
                  bus.req_ack[gnt_id] <= 1'b1;
               end else if (to_hit) begin
                  bus.req_rdata       <= 8'hFF;
                  bus.reg_cs          <= 1'b0;
                  bus.req_ack[gnt_id] <= 1'b1;
               end
            end
            ST_ACK: begin
               if (gnt_id == LAST_ID) begin
                  ptr <= '0;
               end else begin
                  ptr <= gnt_id + 1'b1;
               end
            end
            default: begin
               bus.reg_cs <= 1'b0;
            end
         endcase
      end
   end

   // sticky timeout flag; a new timeout beats a simultaneous clear
   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n) begin
         to_err <= 1'b0;
      end else if (to_set) begin
         to_err <= 1'b1;
      end else if (to_clr) begin
         to_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_reg_arb.sv
// Bench for uart_reg_arb: two requesters, short timeout, a small UART
// register-file model answering after a programmable number of cycles.
module tb_uart_reg_arb;

   localparam int NR = 2;
   localparam int TO = 4;

   logic       mclk = 1'b0;
   logic       reset_n;
   logic       to_clr;
   logic [0:0] gnt_id;
   logic       to_err;

   always #5 mclk = ~mclk;

   uart_reg_arb_if #(.NR(NR)) bus ();

   uart_reg_arb #(.NR(NR), .TO_CYC(TO)) u_dut (
      .mclk    (mclk),
      .reset_n (reset_n),
      .bus     (bus),
      .gnt_id  (gnt_id),
      .to_err  (to_err),
      .to_clr  (to_clr)
   );

   typedef struct {
      int         id;
      bit         chk_data;
      logic [7:0] rdata;
      bit         err;
   } exp_t;

   exp_t       sb_q [$];
   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] mem [16];
   int         uart_lat;
   int         cs_cnt;
   int         last_cs_len;
   logic       snap_wr, snap_be;
   logic [3:0] snap_addr;
   logic [7:0] snap_wdata;
   logic       prev_ack;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive(input int id, input bit wr, input logic [3:0] addr,
                        input logic [7:0] wd, input bit be);
      bus.req_wr[id]             = wr;
      bus.req_be[id]             = be;
      bus.req_addr[id*4 +: 4]    = addr;
      bus.req_wdata[id*8 +: 8]   = wd;
   endtask

   task automatic wait_ack(input int id);
      int n = 0;
      do begin
         @(negedge mclk);
         n++;
      end while (bus.req_ack[id] !== 1'b1 && n < 40);
      if (bus.req_ack[id] !== 1'b1) begin
         check_val("ack_wait", 32'(bus.req_ack), 32'(1) << id);
      end
   endtask

   // one complete access by requester id; lat 0 means the UART never acks
   task automatic xact(input int id, input bit wr, input logic [3:0] addr,
                       input logic [7:0] wd, input bit be, input int lat, input bit err_exp);
      exp_t e;
      int   exp_len;
      uart_lat   = lat;
      e.id       = id;
      e.chk_data = !wr;
      e.err      = err_exp;
      if (lat == 0 || lat > TO) begin
         e.rdata = 8'hFF;
         exp_len = TO;
      end else begin
         e.rdata = mem[addr];
         exp_len = lat;
      end
      sb_q.push_back(e);
      drive(id, wr, addr, wd, be);
      bus.req_cs[id] = 1'b1;
      wait_ack(id);
      @(posedge mclk);
      #1 bus.req_cs[id] = 1'b0;
      check_val("cs_len", 32'(last_cs_len), 32'(exp_len));
      check_val("reg_fields", 32'({snap_wr, snap_be, snap_addr, snap_wdata}),
                32'({wr, be, addr, wd}));
   endtask

   // UART register-port model: acks on the lat-th cycle of reg_cs
   initial begin
      bus.reg_ack   = 1'b0;
      bus.reg_rdata = 8'h00;
      cs_cnt        = 0;
      last_cs_len   = 0;
      forever begin
         @(negedge mclk);
         if (!reset_n) begin
            cs_cnt = 0;
         end else if (bus.reg_cs) begin
            cs_cnt++;
            if (cs_cnt == 1) begin
               snap_wr    = bus.reg_wr;
               snap_be    = bus.reg_be;
               snap_addr  = bus.reg_addr;
               snap_wdata = bus.reg_wdata;
            end else begin
               check_val("reg_stable",
                         32'({bus.reg_wr, bus.reg_be, bus.reg_addr, bus.reg_wdata}),
                         32'({snap_wr, snap_be, snap_addr, snap_wdata}));
            end
         end else begin
            if (cs_cnt != 0) last_cs_len = cs_cnt;
            cs_cnt = 0;
         end
         if (reset_n && bus.reg_cs && uart_lat != 0 && cs_cnt == uart_lat) begin
            bus.reg_ack   = 1'b1;
            bus.reg_rdata = mem[bus.reg_addr];
            if (bus.reg_wr && bus.reg_be) mem[bus.reg_addr] = bus.reg_wdata;
         end else begin
            bus.reg_ack   = 1'b0;
            bus.reg_rdata = 8'($urandom);
         end
      end
   end

   // scoreboard: every ack pops one expected completion
   initial begin
      exp_t e;
      prev_ack = 1'b0;
      forever begin
         @(negedge mclk);
         if (reset_n !== 1'b1) begin
            prev_ack = 1'b0;
         end else begin
            if (prev_ack) check_val("ack_width", 32'(bus.req_ack), 32'd0);
            if (bus.req_ack != '0) begin
               if (sb_q.size() == 0) begin
                  check_val("ack_unexp", 32'(bus.req_ack), 32'd0);
               end else begin
                  e = sb_q.pop_front();
                  check_val("ack_id", 32'(bus.req_ack), 32'(1) << e.id);
                  check_val("gnt_id", 32'(gnt_id), 32'(e.id));
                  if (e.chk_data) check_val("rdata", 32'(bus.req_rdata), 32'(e.rdata));
                  check_val("to_err_ack", 32'(to_err), 32'(e.err));
                  check_val("cs_in_ack", 32'(bus.reg_cs), 32'd0);
               end
            end
            prev_ack = (bus.req_ack != '0);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_reg_cs"},    32'(bus.reg_cs),    32'd0);
      check_val({tag, "_reg_wr"},    32'(bus.reg_wr),    32'd0);
      check_val({tag, "_reg_be"},    32'(bus.reg_be),    32'd0);
      check_val({tag, "_reg_addr"},  32'(bus.reg_addr),  32'd0);
      check_val({tag, "_reg_wdata"}, 32'(bus.reg_wdata), 32'd0);
      check_val({tag, "_req_ack"},   32'(bus.req_ack),   32'd0);
      check_val({tag, "_req_rdata"}, 32'(bus.req_rdata), 32'd0);
      check_val({tag, "_gnt_id"},    32'(gnt_id),        32'd0);
      check_val({tag, "_to_err"},    32'(to_err),        32'd0);
   endtask

   initial begin
      exp_t e;
      reset_n       = 1'b0;
      to_clr        = 1'b0;
      bus.req_cs    = '0;
      bus.req_wr    = '0;
      bus.req_be    = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      uart_lat      = 1;
      for (int i = 0; i < 16; i++) mem[i] = 8'(8'h30 + i);
      mem[2] = 8'h5A;

      repeat (2) @(posedge mclk);
      @(negedge mclk);
      check_reset_outputs("rst");

      // contention from reset: grants alternate 0,1,0,1
      drive(0, 1'b0, 4'h3, 8'h00, 1'b0);
      drive(1, 1'b0, 4'h7, 8'h00, 1'b0);
      uart_lat = 1;
      for (int k = 0; k < 4; k++) begin
         e.id = k % 2; e.chk_data = 1'b1; e.err = 1'b0;
         e.rdata = (k % 2 == 0) ? mem[3] : mem[7];
         sb_q.push_back(e);
      end
      bus.req_cs = 2'b11;
      @(posedge mclk);
      #1 reset_n = 1'b1;
      wait_ack(0); wait_ack(1); wait_ack(0); wait_ack(1);
      @(posedge mclk);
      #1 bus.req_cs = '0;

      // single read, write pass-through, read-back
      xact(0, 1'b0, 4'h2, 8'h00, 1'b1, 2, 1'b0);
      xact(1, 1'b1, 4'h0, 8'h17, 1'b1, 3, 1'b0);
      xact(0, 1'b0, 4'h0, 8'h00, 1'b0, 1, 1'b0);
      xact(1, 1'b0, 4'h5, 8'h00, 1'b1, 2, 1'b0);

      // early drop by requester 0, requester 1 pending
      drive(0, 1'b0, 4'h4, 8'h00, 1'b1);
      drive(1, 1'b0, 4'h6, 8'h00, 1'b1);
      uart_lat = 3;
      e.id = 0; e.chk_data = 1'b1; e.err = 1'b0; e.rdata = mem[4]; sb_q.push_back(e);
      e.id = 1; e.rdata = mem[6]; sb_q.push_back(e);
      bus.req_cs = 2'b11;
      @(posedge mclk);
      @(posedge mclk);
      #1 bus.req_cs[0] = 1'b0;
      wait_ack(0);
      wait_ack(1);
      @(posedge mclk);
      #1 bus.req_cs[1] = 1'b0;
      repeat (8) @(negedge mclk);

      // timeout, clear, ack on the last timeout cycle
      xact(0, 1'b0, 4'h1, 8'h00, 1'b1, 0, 1'b1);
      to_clr = 1'b1;
      @(posedge mclk);
      #1 to_clr = 1'b0;
      @(negedge mclk);
      check_val("to_clr", 32'(to_err), 32'd0);
      xact(1, 1'b0, 4'h9, 8'h00, 1'b1, 4, 1'b0);

      // set wins over a clear held across the timeout
      to_clr = 1'b1;
      xact(0, 1'b0, 4'h1, 8'h00, 1'b1, 0, 1'b1);
      to_clr = 1'b0;
      @(negedge mclk);
      check_val("to_clr_after", 32'(to_err), 32'd0);
      xact(1, 1'b0, 4'h2, 8'h00, 1'b1, 0, 1'b1);

      // reset during a write access by requester 1
      uart_lat = 0;
      drive(1, 1'b1, 4'h5, 8'hA5, 1'b1);
      bus.req_cs[1] = 1'b1;
      @(posedge mclk);
      @(posedge mclk);
      #2 reset_n = 1'b0;
      #1 check_reset_outputs("async_rst");
      @(negedge mclk);
      check_val("rst_no_ack", 32'(bus.req_ack), 32'd0);
      uart_lat = 1;
      e.id = 1; e.chk_data = 1'b0; e.err = 1'b0; e.rdata = 8'h00; sb_q.push_back(e);
      @(posedge mclk);
      #1 reset_n = 1'b1;
      wait_ack(1);
      @(posedge mclk);
      #1 bus.req_cs[1] = 1'b0;

      // pointer restarts at 0 after reset
      xact(0, 1'b0, 4'h3, 8'h00, 1'b1, 1, 1'b0);
      uart_lat = 0;
      drive(1, 1'b0, 4'h6, 8'h00, 1'b1);
      bus.req_cs[1] = 1'b1;
      @(posedge mclk);
      #1 drive(0, 1'b0, 4'h3, 8'h00, 1'b1);
      bus.req_cs[0] = 1'b1;
      @(posedge mclk);
      #2 reset_n = 1'b0;
      uart_lat = 1;
      e.id = 0; e.chk_data = 1'b1; e.err = 1'b0; e.rdata = mem[3]; sb_q.push_back(e);
      e.id = 1; e.rdata = mem[6]; sb_q.push_back(e);
      @(posedge mclk);
      #1 reset_n = 1'b1;
      wait_ack(0);
      @(posedge mclk);
      #1 bus.req_cs[0] = 1'b0;
      wait_ack(1);
      @(posedge mclk);
      #1 bus.req_cs[1] = 1'b0;

      repeat (6) @(negedge mclk);
      check_val("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
